uart_word_serializer: RTL and testbench

//  Downstream partner of the 64-bit byte assembler. Accepts one 64-bit word on a

---
 rtl/uart_word_pkg.sv | 16 +
 rtl/uart_word_serializer.sv | 189 ++++++++++++++++++
 tb/tb_uart_word_serializer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_pkg.sv
// Shared definitions for the UART word path (assembler and serializer).
// Holds the FSM state encoding, the byte width and the default word size.
`timescale 1ns/1ps
package uart_word_pkg;

   localparam int BYTE_W             = 8;
   localparam int WORD_BYTES_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

endpackage

// File: rtl/uart_word_serializer.sv
// uart_word_serializer: takes one word on a valid/ready handshake and sends
// it byte by byte through a byte-wide UART TX (data/en/busy) interface.
// Optional feature macro: UART_WORD_CHECKSUM_EN appends one XOR checksum byte
// after the data bytes; without it exactly WORD_BYTES bytes are sent.
`timescale 1ns/1ps
module uart_word_serializer
   import uart_word_pkg::*;
#(
   parameter int WORD_BYTES = WORD_BYTES_DEFAULT,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [BYTE_W*WORD_BYTES-1:0] word_in,
   input  logic                         word_valid,
   output logic                         word_ready,
   output logic [BYTE_W-1:0]            uart_tx_data,
   output logic                         uart_tx_en,
   input  logic                         uart_tx_busy,
   output logic                         busy,
   output logic                         word_done
);

   localparam int WORD_W = BYTE_W * WORD_BYTES;
   localparam int CNT_W  = $clog2(WORD_BYTES + 1);
`ifdef UART_WORD_CHECKSUM_EN
   localparam int N_BYTES = WORD_BYTES + 1;
   // Counter value of the last data byte; the byte after it is the checksum.
   localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(WORD_BYTES - 1);
`else
   localparam int N_BYTES = WORD_BYTES;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [WORD_W-1:0]   r_shift;
   logic [WORD_W-1:0]   w_shift_next;
   logic [BYTE_W-1:0]   r_tx_data;
   logic                w_accept;
   logic                w_advance;
   logic                w_tx_en;
   logic                w_done;
`ifdef UART_WORD_CHECKSUM_EN
   logic [BYTE_W-1:0]   r_csum;
`endif

   // Byte that goes on the wire first for a given (remaining) word.
   function automatic logic [BYTE_W-1:0] first_byte(input logic [WORD_W-1:0] w);
      if (MSB_FIRST) begin
         return w[WORD_W-1 -: BYTE_W];
      end else begin
         return w[BYTE_W-1:0];
      end
   endfunction

   // Drop the byte just sent so the next one sits in the outgoing position.
   function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w);
      if (MSB_FIRST) begin
         return w << BYTE_W;
      end else begin
         return w >> BYTE_W;
      end
   endfunction

`ifdef UART_WORD_CHECKSUM_EN
   // XOR of all data bytes; order-independent, so computed once at accept.
   function automatic logic [BYTE_W-1:0] xor_bytes(input logic [WORD_W-1:0] w);
      logic [BYTE_W-1:0] acc;
      acc = {BYTE_W{1'b0}};
      for (int i = 0; i < WORD_BYTES; i++) begin
         acc = acc ^ w[i*BYTE_W +: BYTE_W];
      end
      return acc;
   endfunction
`endif

   assign w_shift_next = shift_word(r_shift);

   // State register; reset abandons any word in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic plus the single-cycle strobes (en, done) and datapath controls.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_advance    = 1'b0;
      w_tx_en      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (word_valid) begin
               w_accept     = 1'b1;
               w_next_state = ISSUE;
            end else begin
               w_next_state = IDLE;
            end
         end
         ISSUE: begin
            // en only while the UART is free, so every strobe is latched.
            if (!uart_tx_busy) begin
               w_tx_en      = 1'b1;
               w_next_state = WAIT_HI;
            end else begin
               w_next_state = ISSUE;
            end
         end
         WAIT_HI: begin
            if (uart_tx_busy) begin
               w_next_state = WAIT_LO;
            end else begin
               w_next_state = WAIT_HI;
            end
         end
         WAIT_LO: begin
            if (!uart_tx_busy) begin
               if (r_cnt == LAST_CNT) begin
                  w_done       = 1'b1;
                  w_next_state = IDLE;
               end else begin
                  w_advance    = 1'b1;
                  w_next_state = ISSUE;
               end
            end else begin
               w_next_state = WAIT_LO;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Shift register, byte counter and outgoing byte; data only changes between bytes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_shift   <= {WORD_W{1'b0}};
         r_cnt     <= {CNT_W{1'b0}};
         r_tx_data <= {BYTE_W{1'b0}};
      end else if (w_accept) begin
         r_shift   <= word_in;
         r_cnt     <= {CNT_W{1'b0}};
         r_tx_data <= first_byte(word_in);
      end else if (w_advance) begin
         r_shift <= w_shift_next;
         r_cnt   <= r_cnt + CNT_W'(1);
`ifdef UART_WORD_CHECKSUM_EN
         if (r_cnt == LAST_DATA_CNT) begin
            r_tx_data <= r_csum;
         end else begin
            r_tx_data <= first_byte(w_shift_next);
         end
`else
         r_tx_data <= first_byte(w_shift_next);
`endif
      end else begin
         r_shift   <= r_shift;
         r_cnt     <= r_cnt;
         r_tx_data <= r_tx_data;
      end
   end

`ifdef UART_WORD_CHECKSUM_EN
   // Checksum captured with the word so later word_in changes cannot affect it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_csum <= {BYTE_W{1'b0}};
      end else if (w_accept) begin
         r_csum <= xor_bytes(word_in);
      end else begin
         r_csum <= r_csum;
      end
   end
`endif

   assign word_ready   = (r_state == IDLE);
   assign busy         = !word_ready;
   assign uart_tx_en   = w_tx_en;
   assign uart_tx_data = r_tx_data;
   assign word_done    = w_done;

endmodule

// File: tb/tb_uart_word_serializer.sv
// Self-checking bench for uart_word_serializer. Two instances: [0] MSB first,
// [1] LSB first. A behavioural UART raises busy the cycle after a latched
// strobe and holds it HOLD cycles. Expected bytes are queued when a word is
// driven and compared against the bytes the UART model latched.
`timescale 1ns/1ps
module tb_uart_word_serializer;

   localparam int WB     = 8;
   localparam int HOLD   = 10;
   localparam int BUDGET = 3000;
`ifdef UART_WORD_CHECKSUM_EN
   localparam int NB = WB + 1;
`else
   localparam int NB = WB;
`endif

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic [63:0] word_in    [2];
   logic        word_valid [2];
   logic        word_ready [2];
   logic [7:0]  tx_data    [2];
   logic        tx_en      [2];
   logic        tx_busy    [2];
   logic        busy_o     [2];
   logic        word_done  [2];
   logic        model_busy [2] = '{1'b0, 1'b0};
   int          hold_cnt   [2] = '{0, 0};
   logic        force_busy = 1'b0;

   int en_cnt [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   int acc_cnt [2] = '{0, 0};
   logic [7:0] obs_q0 [$];
   logic [7:0] obs_q1 [$];
   logic [7:0] exp_q  [$];

   int n_cmp = 0;
   int n_err = 0;

   uart_word_serializer #(.WORD_BYTES(WB), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk(clk), .resetn(resetn), .word_in(word_in[0]), .word_valid(word_valid[0]),
      .word_ready(word_ready[0]), .uart_tx_data(tx_data[0]), .uart_tx_en(tx_en[0]),
      .uart_tx_busy(tx_busy[0]), .busy(busy_o[0]), .word_done(word_done[0]));

   uart_word_serializer #(.WORD_BYTES(WB), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk(clk), .resetn(resetn), .word_in(word_in[1]), .word_valid(word_valid[1]),
      .word_ready(word_ready[1]), .uart_tx_data(tx_data[1]), .uart_tx_en(tx_en[1]),
      .uart_tx_busy(tx_busy[1]), .busy(busy_o[1]), .word_done(word_done[1]));

   always #5 clk = ~clk;

   assign tx_busy[0] = model_busy[0] | force_busy;
   assign tx_busy[1] = model_busy[1];

   // UART model: latch on en&&!busy, busy from the next cycle for HOLD cycles.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (tx_en[k] && !tx_busy[k]) begin
            model_busy[k] <= 1'b1;
            hold_cnt[k]   <= HOLD;
         end else if (hold_cnt[k] > 1) begin
            hold_cnt[k] <= hold_cnt[k] - 1;
         end else begin
            hold_cnt[k]   <= 0;
            model_busy[k] <= 1'b0;
         end
      end
   end

   // Monitor: record latched bytes, done pulses and accepts mid-cycle.
   always @(negedge clk) begin
      if (resetn) begin
         for (int k = 0; k < 2; k++) begin
            if (tx_en[k] && !tx_busy[k]) begin
               en_cnt[k]++;
               if (k == 0) obs_q0.push_back(tx_data[k]);
               else        obs_q1.push_back(tx_data[k]);
            end
            if (word_done[k]) done_cnt[k]++;
            if (word_valid[k] && word_ready[k]) acc_cnt[k]++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected wire order from the word value and the instance's byte order.
   task automatic push_expected(input int k, input logic [63:0] w);
      logic [7:0] b;
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < WB; i++) begin
         if (k == 0) b = w[8*(WB-1-i) +: 8];
         else        b = w[8*i +: 8];
         exp_q.push_back(b);
         x = x ^ b;
      end
`ifdef UART_WORD_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   // Present a word and return at posedge+1 after the accepting edge.
   task automatic send(input int k, input logic [63:0] w);
      word_in[k]    = w;
      word_valid[k] = 1'b1;
      push_expected(k, w);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (word_ready[k]) break;
      end
      tick();
      word_valid[k] = 1'b0;
   endtask

   // Wait for word_done on instance k, counting cycles where ready was high.
   task automatic wait_done(input int k, output int ready_viol);
      bit seen;
      seen = 1'b0;
      ready_viol = 0;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         if (word_ready[k]) ready_viol++;
         if (word_done[k]) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL done_timeout: inst %0d got no word_done within %0d cycles", k, BUDGET);
      end
      tick();
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (word_ready[0] !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", word_ready[0]); end
      n_cmp++; if (busy_o[0] !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy_o[0]); end
      n_cmp++; if (tx_en[0] !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b expected 0", tx_en[0]); end
      n_cmp++; if (tx_data[0] !== 8'h00) begin n_err++; $display("FAIL rst_data: got %02h expected 00", tx_data[0]); end
      n_cmp++; if (word_done[0] !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", word_done[0]); end
      n_cmp++; if (tx_data[1] !== 8'h00) begin n_err++; $display("FAIL rst_data_lsb: got %02h expected 00", tx_data[1]); end
      tick(); tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_msb_first(input logic [63:0] w, input string tag);
      int en0, dn0, viol;
      logic [7:0] e, o;
      obs_q0.delete(); exp_q.delete();
      en0 = en_cnt[0]; dn0 = done_cnt[0];
      send(0, w);
      @(negedge clk);
      n_cmp++; if (tx_en[0] !== 1'b1) begin n_err++; $display("FAIL %s_latency: en got %b expected 1 one cycle after accept", tag, tx_en[0]); end
      wait_done(0, viol);
      n_cmp++; if (viol != 0) begin n_err++; $display("FAIL %s_ready_low: ready high %0d cycles, expected 0", tag, viol); end
      n_cmp++; if (en_cnt[0] - en0 != NB) begin n_err++; $display("FAIL %s_en_count: got %0d expected %0d", tag, en_cnt[0] - en0, NB); end
      n_cmp++; if (done_cnt[0] - dn0 != 1) begin n_err++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt[0] - dn0); end
      n_cmp++; if (word_ready[0] !== 1'b1 || busy_o[0] !== 1'b0) begin n_err++; $display("FAIL %s_idle: ready %b busy %b expected 1/0", tag, word_ready[0], busy_o[0]); end
      n_cmp++; if (obs_q0.size() != exp_q.size()) begin n_err++; $display("FAIL %s_bytes: got %0d expected %0d", tag, obs_q0.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q0.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q0.pop_front();
         n_cmp++; if (o !== e) begin n_err++; $display("FAIL %s_byte: got %02h expected %02h", tag, o, e); end
      end
`ifdef UART_WORD_CHECKSUM_EN
      if (w == 64'h0102040810204080) begin
         n_cmp++; if (tx_data[0] !== 8'hFF) begin n_err++; $display("FAIL %s_checksum: got %02h expected ff", tag, tx_data[0]); end
      end
`endif
   endtask

   task automatic test_lsb_first();
      int en0, viol;
      logic [7:0] e, o;
      obs_q1.delete(); exp_q.delete();
      en0 = en_cnt[1];
      send(1, 64'h0123456789ABCDEF);
      wait_done(1, viol);
      n_cmp++; if (en_cnt[1] - en0 != NB) begin n_err++; $display("FAIL lsb_en_count: got %0d expected %0d", en_cnt[1] - en0, NB); end
      n_cmp++; if (obs_q1.size() != exp_q.size()) begin n_err++; $display("FAIL lsb_bytes: got %0d expected %0d", obs_q1.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q1.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q1.pop_front();
         n_cmp++; if (o !== e) begin n_err++; $display("FAIL lsb_byte: got %02h expected %02h", o, e); end
      end
   endtask

   task automatic test_busy_at_accept();
      int seen, n, viol;
      logic [7:0] e, o;
      obs_q0.delete(); exp_q.delete();
      force_busy = 1'b1;
      send(0, 64'hA5A5_0F0F_3C3C_9696);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (tx_en[0]) seen++;
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL busy_no_en: en seen %0d cycles while busy, expected 0", seen); end
      tick();
      force_busy = 1'b0;
      n = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         n++;
         if (tx_en[0]) break;
      end
      n_cmp++; if (n != 1) begin n_err++; $display("FAIL busy_release_latency: got %0d cycles expected 1", n); end
      wait_done(0, viol);
      n_cmp++; if (obs_q0.size() != exp_q.size()) begin n_err++; $display("FAIL busy_bytes: got %0d expected %0d", obs_q0.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q0.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q0.pop_front();
         n_cmp++; if (o !== e) begin n_err++; $display("FAIL busy_byte: got %02h expected %02h", o, e); end
      end
   endtask

   task automatic test_hold_valid();
      int a0, viol;
      logic [63:0] w1, w2;
      logic [7:0] e, o;
      w1 = 64'hDEAD_BEEF_CAFE_F00D;
      w2 = 64'h1122_3344_5566_7788;
      obs_q0.delete(); exp_q.delete();
      a0 = acc_cnt[0];
      word_in[0] = w1;
      word_valid[0] = 1'b1;
      tick();
      push_expected(0, w1);
      for (int c = 0; c < 5; c++) begin
         word_in[0] = {$urandom, $urandom};
         tick();
      end
      word_in[0] = w2;
      push_expected(0, w2);
      wait_done(0, viol);
      n_cmp++; if (acc_cnt[0] - a0 != 1) begin n_err++; $display("FAIL hold_early_accept: accepts %0d expected 1", acc_cnt[0] - a0); end
      n_cmp++; if (word_ready[0] !== 1'b1) begin n_err++; $display("FAIL hold_idle_ready: got %b expected 1", word_ready[0]); end
      tick();
      word_valid[0] = 1'b0;
      n_cmp++; if (acc_cnt[0] - a0 != 2) begin n_err++; $display("FAIL hold_second_accept: accepts %0d expected 2", acc_cnt[0] - a0); end
      wait_done(0, viol);
      n_cmp++; if (obs_q0.size() != exp_q.size()) begin n_err++; $display("FAIL hold_bytes: got %0d expected %0d", obs_q0.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q0.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q0.pop_front();
         n_cmp++; if (o !== e) begin n_err++; $display("FAIL hold_byte: got %02h expected %02h", o, e); end
      end
   endtask

   task automatic test_reset_mid_word();
      int dn0, viol;
      logic [7:0] e, o;
      obs_q0.delete(); exp_q.delete();
      send(0, 64'h0F1E_2D3C_4B5A_6978);
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         if (obs_q0.size() >= 3 && tx_en[0]) break;
      end
      dn0 = done_cnt[0];
      #1 resetn = 1'b0;
      #1;
      n_cmp++; if (tx_en[0] !== 1'b0) begin n_err++; $display("FAIL midrst_en: got %b expected 0", tx_en[0]); end
      n_cmp++; if (busy_o[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy_o[0]); end
      n_cmp++; if (word_ready[0] !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", word_ready[0]); end
      tick(); tick();
      resetn = 1'b1;
      tick();
      n_cmp++; if (done_cnt[0] != dn0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt[0] - dn0); end
      for (int c = 0; c < 50; c++) begin
         if (!model_busy[0]) break;
         tick();
      end
      obs_q0.delete(); exp_q.delete();
      send(0, 64'h8877_6655_4433_2211);
      wait_done(0, viol);
      n_cmp++; if (obs_q0.size() != exp_q.size()) begin n_err++; $display("FAIL midrst_bytes: got %0d expected %0d", obs_q0.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q0.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q0.pop_front();
         n_cmp++; if (o !== e) begin n_err++; $display("FAIL midrst_byte: got %02h expected %02h", o, e); end
      end
   endtask

   initial begin
      word_in[0] = 64'h0; word_in[1] = 64'h0;
      word_valid[0] = 1'b0; word_valid[1] = 1'b0;
      test_reset();
      test_msb_first(64'h0123456789ABCDEF, "msb");
      test_lsb_first();
      test_msb_first(64'h0102040810204080, "csum");
      test_busy_at_accept();
      test_hold_valid();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
